// File: rtl/bus_xfer_sched_pkg.sv
// rtl/bus_xfer_sched_pkg.sv - shared constants and types for the bus transfer sequencer
// Purpose: code width, bus source select codes and the sequencer FSM state type.
package bus_xfer_sched_pkg;

  localparam int CODE_W   = 5;
  localparam int NUM_REGS = 19;

  // Named bus sources; code 0 leaves the bus undriven.
  localparam logic [CODE_W-1:0] SEL_NONE = 5'd0;
  localparam logic [CODE_W-1:0] SEL_AC   = 5'd1;
  localparam logic [CODE_W-1:0] SEL_MEM  = 5'd15;
  localparam logic [CODE_W-1:0] SEL_RR   = 5'd16;
  localparam logic [CODE_W-1:0] SEL_RT4  = 5'd17;
  localparam logic [CODE_W-1:0] SEL_RL1  = 5'd18;
  localparam logic [CODE_W-1:0] SEL_RL2  = 5'd19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_LOAD  = 2'd3
  } xfer_state_t;

endpackage

// File: rtl/bus_xfer_sched_if.sv
// rtl/bus_xfer_sched_if.sv - command and bus-control signal bundle for the sequencer
// Purpose: groups the command handshake and the mux/load outputs.
// Ports: cmd_valid/cmd_src/cmd_dst (to sequencer), cmd_ready, mux_sel, load_en,
//        busy, xfer_done, err (from sequencer).
// Modports: master = control unit side, slave = sequencer side.
interface bus_xfer_sched_if #(
  parameter int SEL_W   = bus_xfer_sched_pkg::CODE_W,
  parameter int NUM_DST = bus_xfer_sched_pkg::NUM_REGS
);
  logic               cmd_valid;
  logic [SEL_W-1:0]   cmd_src;
  logic [SEL_W-1:0]   cmd_dst;
  logic               cmd_ready;
  logic [SEL_W-1:0]   mux_sel;
  logic [NUM_DST-1:0] load_en;
  logic               busy;
  logic               xfer_done;
  logic               err;

  modport master (
    output cmd_valid, cmd_src, cmd_dst,
    input  cmd_ready, mux_sel, load_en, busy, xfer_done, err
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst,
    output cmd_ready, mux_sel, load_en, busy, xfer_done, err
  );
endinterface

// File: rtl/bus_cmd_fifo.sv
// rtl/bus_cmd_fifo.sv - synchronous command FIFO with occupancy count
// Purpose: DEPTH x WIDTH show-ahead FIFO; dout is the head entry whenever !empty.
// Ports: clk, rst (async active-high), push/din, pop/dout, full, empty, count.
// Push while full and pop while empty are ignored.
module bus_cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is kept out of the reset domain; stale entries are never read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/bus_xfer_sched.sv
// rtl/bus_xfer_sched.sv - sequencer driving the shared bus mux select and register loads
// Purpose: queues (src, dst) transfer commands and plays each one out as
//          SETUP -> [WAIT x MEM_LAT for MEM source] -> LOAD, pulsing one load enable.
// Ports: clk, rst (async active-high), bus (slave modport): cmd_valid/cmd_src/cmd_dst
//        in, cmd_ready, mux_sel, load_en (one-hot, bit k = dst k+1), busy,
//        xfer_done, err (sticky bad-command flag) out.
module bus_xfer_sched #(
  parameter int SEL_W    = bus_xfer_sched_pkg::CODE_W,
  parameter int NUM_DST  = bus_xfer_sched_pkg::NUM_REGS,
  parameter int DEPTH    = 4,
  parameter int MEM_CODE = 15,
  parameter int MEM_LAT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  bus_xfer_sched_if.slave  bus
);
  import bus_xfer_sched_pkg::*;

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  xfer_state_t        state, state_nxt;
  logic [LAT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic [SEL_W-1:0]   cur_src, cur_dst;
  logic [2*SEL_W-1:0] head;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic               cmd_take, src_ok, dst_ok, err_q;

  // Acceptance only looks at the registered full flag, so a full FIFO is
  // never bypassed even when the FSM pops in the same cycle.
  assign cmd_take  = bus.cmd_valid && !fifo_full;
  assign src_ok    = (bus.cmd_src != '0) && (bus.cmd_src <= SEL_W'(NUM_DST));
  assign dst_ok    = (bus.cmd_dst != '0) && (bus.cmd_dst <= SEL_W'(NUM_DST));
  assign fifo_push = cmd_take && src_ok && dst_ok;

  assign bus.cmd_ready = !fifo_full;
  assign bus.busy      = (fifo_count != '0) || (state != ST_IDLE);
  assign bus.err       = err_q;

  bus_cmd_fifo #(.WIDTH(2*SEL_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   ({bus.cmd_src, bus.cmd_dst}),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    fifo_pop      = 1'b0;
    bus.mux_sel   = '0;
    bus.load_en   = '0;
    bus.xfer_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        bus.mux_sel = cur_src;
        // Counter preloaded to MEM_LAT-1 so WAIT lasts exactly MEM_LAT cycles.
        if (cur_src == SEL_W'(MEM_CODE) && MEM_LAT > 0) begin
          state_nxt    = ST_WAIT;
          wait_cnt_nxt = LAT_W'(MEM_LAT - 1);
        end else begin
          state_nxt = ST_LOAD;
        end
      end
      ST_WAIT: begin
        bus.mux_sel = cur_src;
        if (wait_cnt == '0) state_nxt = ST_LOAD;
        else                wait_cnt_nxt = wait_cnt - 1'b1;
      end
      ST_LOAD: begin
        bus.mux_sel   = cur_src;
        bus.load_en   = {{(NUM_DST-1){1'b0}}, 1'b1} << (cur_dst - 1'b1);
        bus.xfer_done = 1'b1;
        // Chaining straight into SETUP keeps back-to-back transfers gap-free.
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ST_SETUP;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      cur_src  <= '0;
      cur_dst  <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (fifo_pop) {cur_src, cur_dst} <= head;
      if (cmd_take && !(src_ok && dst_ok)) err_q <= 1'b1;
    end
  end
endmodule
